// File: rtl/cnt_share_arb_if.sv
// -----------------------------------------------------------------------------
// cnt_share_arb_if -- request/grant and counter bus of cnt_share_arb.
//
// Signals:
//   req      [NREQ]     per-requester request level, held until done
//   len      [NREQ*W]   packed burst lengths, slice i for requester i
//   gnt      [NREQ]     one-hot grant, zero when no burst runs
//   busy                high while a burst runs
//   a        [W]        shared counter value
//   b        [W]        counter value from the previous cycle
//   done                single-cycle pulse at burst end
//   done_id  [IDW]      index of the finished requester (0 when done=0)
//   aborted             done qualifier: burst ended because req dropped
//
// Modports: master drives req/len (requesters), slave is the arbiter.
// -----------------------------------------------------------------------------
interface cnt_share_arb_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              done;
    logic [IDW-1:0]    done_id;
    logic              aborted;

    modport master (
        output req, len,
        input  gnt, busy, a, b, done, done_id, aborted
    );

    modport slave (
        input  req, len,
        output gnt, busy, a, b, done, done_id, aborted
    );
endinterface

// File: rtl/cnt_share_arb.sv
// -----------------------------------------------------------------------------
// cnt_share_arb -- one W-bit counter shared by NREQ requesters.
//
// A requester wins the counter, runs a burst of len[id] increments (0 means
// 2^W), and the arbiter pulses done with the finishing id. Dropping req during
// the burst aborts it. IDLE -> RUN -> DONE -> IDLE; arbitration only in IDLE,
// so there is always one dead cycle between bursts.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   cnt_share_arb_if.slave (req, len in; gnt, busy, a, b, done,
//         done_id, aborted out; all outputs registered)
//
// Build option:
//   CNT_SHARE_ARB_FIXED_PRIO_EN  defined   -> lowest asserted index wins
//                                undefined -> round-robin after last finisher
// -----------------------------------------------------------------------------
module cnt_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    cnt_share_arb_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            busy_q, busy_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    remain_q, remain_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            done_q, done_d;
    logic [IDW-1:0]  done_id_q, done_id_d;
    logic            aborted_q, aborted_d;

    logic [IDW-1:0]  win;
    logic [IDW-1:0]  cand;
    logic            finish;
    logic [W-1:0]    len_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
        assign len_arr[gi] = bus.len[gi*W +: W];
    end

`ifdef CNT_SHARE_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest asserted index is written last.
    always_comb begin
        win  = '0;
        cand = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IDW'(i);
            if (bus.req[cand]) win = cand;
        end
    end
`else
    logic [IDW-1:0] last_id_q, last_id_d;

    // Scan from farthest (last_id itself) to nearest (last_id+1) so the
    // nearest asserted requester after the last finisher is written last.
    always_comb begin
        win  = last_id_q;
        cand = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IDW'((int'(last_id_q) + i) % NREQ);
            if (bus.req[cand]) win = cand;
        end
    end
`endif

    // Burst ends on the last increment or when the owner drops its request.
    assign finish = !bus.req[id_q] || (remain_q == W'(1));

    always_comb begin
        // NOTE: every next-state variable gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d   = state_q;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        a_d       = a_q;
        b_d       = b_q;
        remain_d  = remain_q;
        id_d      = id_q;
        done_d    = 1'b0;
        done_id_d = '0;
        aborted_d = 1'b0;
`ifndef CNT_SHARE_ARB_FIXED_PRIO_EN
        last_id_d = last_id_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d  = RUN;
                    id_d     = win;
                    gnt_d    = NREQ'(1) << win;
                    busy_d   = 1'b1;
                    a_d      = '0;
                    b_d      = '0;
                    remain_d = len_arr[win];  // 0 wraps through 2^W decrements
                end
            end
            RUN: begin
                if (bus.req[id_q]) begin
                    a_d      = a_q + 1'b1;
                    b_d      = a_q;
                    remain_d = remain_q - 1'b1;
                end
                if (finish) begin
                    state_d   = DONE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    aborted_d = !bus.req[id_q];
`ifndef CNT_SHARE_ARB_FIXED_PRIO_EN
                    last_id_d = id_q;
`endif
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            remain_q  <= '0;
            id_q      <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            aborted_q <= 1'b0;
`ifndef CNT_SHARE_ARB_FIXED_PRIO_EN
            last_id_q <= IDW'(NREQ - 1);  // first pick is requester 0
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            a_q       <= a_d;
            b_q       <= b_d;
            remain_q  <= remain_d;
            id_q      <= id_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            aborted_q <= aborted_d;
`ifndef CNT_SHARE_ARB_FIXED_PRIO_EN
            last_id_q <= last_id_d;
`endif
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.busy    = busy_q;
    assign bus.a       = a_q;
    assign bus.b       = b_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.aborted = aborted_q;

endmodule

// File: tb/tb_cnt_share_arb.sv
// -----------------------------------------------------------------------------
// tb_cnt_share_arb -- directed bench for cnt_share_arb (NREQ=4, W=4).
// Each step drives inputs, takes one rising edge, and compares all outputs
// 1 time unit later against hand-computed values.
// -----------------------------------------------------------------------------
module tb_cnt_share_arb;

    typedef struct packed {
        logic [3:0] gnt;
        logic       busy;
        logic [3:0] a;
        logic [3:0] b;
        logic       done;
        logic [1:0] done_id;
        logic       aborted;
    } out_t;

    typedef struct {
        string       name;
        logic        rst;
        logic [3:0]  req;
        logic [15:0] len;
        out_t        exp;
    } vec_t;

`ifdef CNT_SHARE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk;
    logic rst;
    int   nvec;
    int   nmis;
    vec_t tbl[$];

    cnt_share_arb_if #(.NREQ(4), .W(4)) bus ();

    cnt_share_arb #(.NREQ(4), .W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t mk(logic [3:0] g, logic bz, logic [3:0] av,
                                logic [3:0] bv, logic d, logic [1:0] id,
                                logic ab);
        mk = {g, bz, av, bv, d, id, ab};
    endfunction

    task automatic add(string name, logic r, logic [3:0] rq, logic [15:0] ln,
                       out_t exp);
        vec_t v;
        v.name = name;
        v.rst  = r;
        v.req  = rq;
        v.len  = ln;
        v.exp  = exp;
        tbl.push_back(v);
    endtask

    task automatic step(logic r, logic [3:0] rq, logic [15:0] ln);
        rst     = r;
        bus.req = rq;
        bus.len = ln;
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, out_t exp);
        out_t act;
        act = {bus.gnt, bus.busy, bus.a, bus.b, bus.done, bus.done_id, bus.aborted};
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got gnt=%b busy=%b a=%0d b=%0d done=%b id=%0d ab=%b, expected gnt=%b busy=%b a=%0d b=%0d done=%b id=%0d ab=%b",
                     name, act.gnt, act.busy, act.a, act.b, act.done, act.done_id, act.aborted,
                     exp.gnt, exp.busy, exp.a, exp.b, exp.done, exp.done_id, exp.aborted);
        end
    endtask

    initial begin
        int g;
        nvec    = 0;
        nmis    = 0;
        rst     = 1'b1;
        bus.req = '0;
        bus.len = '0;

        // Reset, then a single 3-increment burst for requester 0.
        add("rst0",   1, 4'b0001, 16'h0003, mk(4'b0000, 0, 0, 0, 0, 0, 0));
        add("rst1",   1, 4'b0001, 16'h0003, mk(4'b0000, 0, 0, 0, 0, 0, 0));
        add("b3_gnt", 0, 4'b0001, 16'h0003, mk(4'b0001, 1, 0, 0, 0, 0, 0));
        add("b3_r1",  0, 4'b0001, 16'h0003, mk(4'b0001, 1, 1, 0, 0, 0, 0));
        add("b3_r2",  0, 4'b0001, 16'h0003, mk(4'b0001, 1, 2, 1, 0, 0, 0));
        add("b3_done",0, 4'b0001, 16'h0003, mk(4'b0000, 0, 3, 2, 1, 0, 0));
        add("idle0",  0, 4'b0000, 16'h0003, mk(4'b0000, 0, 3, 2, 0, 0, 0));
        add("idle1",  0, 4'b0000, 16'h0003, mk(4'b0000, 0, 3, 2, 0, 0, 0));
        // Reset overrides pending requests; then five len=1 bursts, all req high.
        add("rst_req",1, 4'b1111, 16'h1111, mk(4'b0000, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            g = FIXED ? 0 : (k % 4);
            add($sformatf("arb%0d_gnt", k),  0, 4'b1111, 16'h1111,
                mk(4'(1 << g), 1, 0, 0, 0, 0, 0));
            add($sformatf("arb%0d_done", k), 0, 4'b1111, 16'h1111,
                mk(4'b0000, 0, 1, 0, 1, 2'(g), 0));
            add($sformatf("arb%0d_dead", k), 0, 4'b1111, 16'h1111,
                mk(4'b0000, 0, 1, 0, 0, 0, 0));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].len);
            check(tbl[i].name, tbl[i].exp);
        end

        // len=0 means 16 increments; a wraps 15->0 on the final one.
        step(1, 4'b0001, 16'h0000);
        check("wrap_rst", mk(4'b0000, 0, 0, 0, 0, 0, 0));
        step(0, 4'b0001, 16'h0000);
        check("wrap_gnt", mk(4'b0001, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 16; k++) begin
            step(0, 4'b0001, 16'h0000);
            if (k < 15)
                check($sformatf("wrap_r%0d", k), mk(4'b0001, 1, 4'(k + 1), 4'(k), 0, 0, 0));
            else
                check("wrap_done", mk(4'b0000, 0, 0, 15, 1, 0, 0));
        end
        step(0, 4'b0000, 16'h0000);
        check("wrap_idle", mk(4'b0000, 0, 0, 15, 0, 0, 0));

        // Requester 2, len=8, aborted after 3 increments. len changes and
        // activity on other req lines during the burst must not matter.
        step(0, 4'b0100, 16'h0800);
        check("ab_gnt", mk(4'b0100, 1, 0, 0, 0, 0, 0));
        step(0, 4'b0101, 16'h0100);
        check("ab_r1", mk(4'b0100, 1, 1, 0, 0, 0, 0));
        step(0, 4'b0100, 16'h0100);
        check("ab_r2", mk(4'b0100, 1, 2, 1, 0, 0, 0));
        step(0, 4'b0111, 16'h0100);
        check("ab_r3", mk(4'b0100, 1, 3, 2, 0, 0, 0));
        step(0, 4'b0001, 16'h0100);
        check("ab_done", mk(4'b0000, 0, 3, 2, 1, 2, 1));

        // Next search starts at requester 3 (round-robin); 3 is requested.
        g = FIXED ? 0 : 3;
        step(0, 4'b1011, 16'h9999);
        check("ab_dead", mk(4'b0000, 0, 3, 2, 0, 0, 0));
        step(0, 4'b1011, 16'h9999);
        check("after_ab_gnt", mk(4'(1 << g), 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            step(0, 4'b1011, 16'h9999);
            check($sformatf("pre_rst_r%0d", k), mk(4'(1 << g), 1, 4'(k + 1), 4'(k), 0, 0, 0));
        end

        // Reset mid-burst at a=5: everything clears, no done pulse, regrant 0.
        step(1, 4'b1011, 16'h9999);
        check("mid_rst", mk(4'b0000, 0, 0, 0, 0, 0, 0));
        step(0, 4'b1011, 16'h9999);
        check("regrant", mk(4'b0001, 1, 0, 0, 0, 0, 0));
        step(0, 4'b1011, 16'h9999);
        check("regrant_r1", mk(4'b0001, 1, 1, 0, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/cnt_share_arb.md
CNT_SHARE_ARB -- requirements
Module: cnt_share_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the counter; range 2..8.
REQ-002 Parameter W, default 4: counter width and burst-length width.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port req  input  NREQ  per-requester request level; held high until the requester's done.
REQ-006 Port len  input  NREQ*W  packed burst lengths; slice i belongs to requester i; sampled only at grant.
REQ-007 Port gnt  output  NREQ  one-hot grant; all zero when no burst is running.
REQ-008 Port busy  output  1  high while a burst is running.
REQ-009 Port a  output  W  shared counter value.
REQ-010 Port b  output  W  counter value from the previous cycle.
REQ-011 Port done  output  1  single-cycle pulse at burst end.
REQ-012 Port done_id  output  clog2(NREQ)  index of the finished requester; valid while done=1.
REQ-013 Port aborted  output  1  qualifies done: burst ended because req dropped.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; state encoding is free.
REQ-015 IDLE: with any req bit high at an edge, that edge SHALL select winner id, set gnt[id]=1, busy=1, remain=len[id], a=0, b=0, and enter RUN.
REQ-016 IDLE with req=0: gnt=0, busy=0, a and b SHALL hold their values.
REQ-017 Winner selection: round-robin, searching from last_id+1 upward with modulo-NREQ wrap; last_id is the most recently finished id.
REQ-018 RUN, each edge: a<=a+1 (modulo 2^W, wraps 15->0 at W=4), b<=a (old a), remain<=remain-1.
REQ-019 len value 0 SHALL mean 2^W increments.
REQ-020 RUN with remain==1 at an edge: that edge performs the final increment and enters DONE; a burst of length L therefore occupies exactly L RUN cycles.
REQ-021 RUN with req[id]==0 at an edge: no increment; enter DONE with aborted=1.
REQ-022 DONE lasts one cycle: done=1, done_id=id, gnt=0, busy=0, a/b held; last_id<=id; next state IDLE.
REQ-023 Arbitration SHALL NOT run in DONE; the earliest next grant comes one edge after done, giving one dead cycle between bursts.
REQ-024 req changes on non-granted lines during RUN SHALL NOT affect the current burst.
REQ-025 len changes after grant SHALL be ignored.
REQ-026 done, done_id and aborted SHALL be registered outputs; done_id and aborted are 0 when done=0.

Reset
REQ-027 rst=1 at an edge SHALL force: state IDLE, gnt=0, busy=0, a=0, b=0, done=0, done_id=0, aborted=0, remain=0, last_id=NREQ-1 (first round-robin pick is requester 0).
REQ-028 rst SHALL override all other inputs; a reset during RUN ends the burst with no done pulse.

Configuration
REQ-029 Macro CNT_SHARE_ARB_FIXED_PRIO_EN defined: winner is the lowest-indexed asserted req; last_id is unused.
REQ-030 Macro CNT_SHARE_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-017.
REQ-031 No other behaviour SHALL differ between the two builds.

Verification
REQ-032 rst 2 cycles, then req=4'b0001 with len0=3 -> gnt=0001 for 3 cycles; a=1,2,3; b=0,1,2; then done=1, done_id=0, aborted=0, a=3.
REQ-033 req=4'b1111, all len=1, held high, round-robin build -> grants in order 0,1,2,3,0, each followed by done plus one dead cycle.
REQ-034 Same stimulus as REQ-033 in the CNT_SHARE_ARB_FIXED_PRIO_EN build -> requester 0 granted every time.
REQ-035 len0=0 at W=4 -> 16 RUN cycles; a wraps 15->0; final a=0; done at cycle 17 after grant.
REQ-036 Grant requester 2 with len2=8, drop req[2] after 3 increments -> a holds at 3; done=1, done_id=2, aborted=1; next grant is searched from requester 3.
REQ-037 rst=1 during RUN with a=5 -> next edge a=0, b=0, gnt=0, busy=0, no done pulse; with req held, regrant to requester 0.
